ecc_apb_sequencer: RTL

APB master controller that runs one ecc_enc_dec operation per accepted job. For each job it programs DATA_IN, CODEWORD_WIDTH and NOISE over APB, then writes CTRL, which starts the operation. It then waits for operation_done, captures data_out and err_num, and returns them on a valid/ready result port. It sits between a job source (test sequencer or host logic) and the ecc_enc_dec APB slave. It is the only APB master on that bus.

---
 rtl/ecc_apb_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: APB master that runs one ecc_enc_dec job at a time.
// It writes DATA_IN, CODEWORD_WIDTH, NOISE and then CTRL. It waits for
// operation_done, or for a timeout, and returns the result on a
// valid/ready port.
module ecc_apb_sequencer #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_cmd,
  input  logic [1:0]                 job_width,
  input  logic [AMBA_WORD-1:0]       job_data,
  input  logic [AMBA_WORD-1:0]       job_noise,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [AMBA_WORD-1:0]       res_data,
  output logic [1:0]                 res_err,
  output logic [1:0]                 res_status,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PWRITE,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       operation_done,
  input  logic [AMBA_WORD-1:0]       data_out,
  input  logic [1:0]                 err_num
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AMBA_ADDR_WIDTH-1:0] A_CTRL  = AMBA_ADDR_WIDTH'(32'h00);
  localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA  = AMBA_ADDR_WIDTH'(32'h04);
  localparam logic [AMBA_ADDR_WIDTH-1:0] A_WIDTH = AMBA_ADDR_WIDTH'(32'h08);
  localparam logic [AMBA_ADDR_WIDTH-1:0] A_NOISE = AMBA_ADDR_WIDTH'(32'h0C);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_cmd, r_width, r_wi;
  logic [AMBA_WORD-1:0] r_data, r_noise;
  logic [CW-1:0]        r_cnt;
  logic                 w_accept, w_illegal, w_tmo;
  logic [1:0]           w_wi_nxt;
  logic [AMBA_ADDR_WIDTH-1:0] w_addr_nxt;
  logic [AMBA_WORD-1:0]       w_wdata_nxt;

  // job_ready is gated by rst so that it reads 0 while reset is held
  assign job_ready = rst & (r_state == S_IDLE);
  assign w_accept  = job_valid & job_ready;
  assign w_illegal = (job_cmd == 2'd3) | (job_width == 2'd3);
  assign w_tmo     = (r_cnt >= CW'(TIMEOUT_CYCLES - 1));

  // APB control strobes are decoded from the state, so reset clears them at once
  assign PSEL      = (r_state == S_SETUP) | (r_state == S_ACCESS);
  assign PENABLE   = (r_state == S_ACCESS);
  assign PWRITE    = PSEL;
  assign res_valid = (r_state == S_RESP);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_illegal ? S_RESP : S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: w_next = (r_wi == 2'd3) ? S_WAIT : S_SETUP;
      S_WAIT:   if (operation_done || w_tmo) w_next = S_RESP;
      S_RESP:   if (res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Address and data for the next register write in the fixed write order
  always_comb begin
    w_wi_nxt    = r_wi + 2'd1;
    w_addr_nxt  = A_CTRL;
    w_wdata_nxt = {{(AMBA_WORD-2){1'b0}}, r_cmd};
    case (w_wi_nxt)
      2'd0: begin w_addr_nxt = A_DATA;  w_wdata_nxt = r_data; end
      2'd1: begin w_addr_nxt = A_WIDTH; w_wdata_nxt = {{(AMBA_WORD-2){1'b0}}, r_width}; end
      2'd2: begin w_addr_nxt = A_NOISE; w_wdata_nxt = r_noise; end
      default: ;
    endcase
  end

  // Job latch, APB address/data, timeout counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd      <= '0;
      r_width    <= '0;
      r_data     <= '0;
      r_noise    <= '0;
      r_wi       <= '0;
      r_cnt      <= '0;
      PADDR      <= '0;
      PWDATA     <= '0;
      res_data   <= '0;
      res_err    <= '0;
      res_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cmd   <= job_cmd;
          r_width <= job_width;
          r_data  <= job_data;
          r_noise <= job_noise;
          r_wi    <= 2'd0;
          if (w_illegal) begin
            res_data   <= '0;
            res_err    <= '0;
            res_status <= 2'b10;
          end else begin
            PADDR  <= A_DATA;
            PWDATA <= job_data;
          end
        end
        S_ACCESS: begin
          if (r_wi != 2'd3) begin
            r_wi   <= w_wi_nxt;
            PADDR  <= w_addr_nxt;
            PWDATA <= w_wdata_nxt;
          end else begin
            r_cnt <= '0;
          end
        end
        S_WAIT: begin
          // a done pulse in the final counted cycle still wins over the timeout
          if (operation_done) begin
            res_data   <= data_out;
            res_err    <= err_num;
            res_status <= 2'b00;
          end else if (w_tmo) begin
            res_data   <= '0;
            res_err    <= '0;
            res_status <= 2'b01;
          end else if (r_cnt < CW'(TIMEOUT_CYCLES)) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
